// File: rtl/inst_queue_if.sv
// Instruction queue bus: RX prefetch beats, request accounting, the decoder
// head-word port and the scheduler immediate port.
// The slave modport is the queue side; the master modport is the
// prefetcher/decoder/scheduler side.
interface inst_queue_if #(
  parameter int NSHIFT = 2
);
  logic              flush;
  logic              req_issued;
  logic              room;
  logic              rx_valid;
  logic [NSHIFT-1:0] rx_data;
  logic [15:0]       inst_word;
  logic              inst_word_valid;
  logic              inst_word_pop;
  logic              load_imm16;
  logic              imm16_loaded;
  logic              next_imm_data;
  logic [NSHIFT-1:0] imm_data;

  modport master (
    output flush, req_issued, rx_valid, rx_data, inst_word_pop,
           load_imm16, next_imm_data,
    input  room, inst_word, inst_word_valid, imm16_loaded, imm_data
  );

  modport slave (
    input  flush, req_issued, rx_valid, rx_data, inst_word_pop,
           load_imm16, next_imm_data,
    output room, inst_word, inst_word_valid, imm16_loaded, imm_data
  );
endinterface

// File: rtl/inst_queue.sv
// Instruction prefetch queue.
// Assembles 16-bit words from NSHIFT-bit RX beats into a small FIFO. The
// head word goes to the decoder, and the scheduler can pull the head into a
// rotating immediate register. Outstanding prefetch requests are tracked so
// the FIFO never overfills. A flush marks in-flight words stale so they are
// dropped on arrival.
// Optional macro INST_QUEUE_BYPASS_EN: when the queue is empty, a completing
// word is shown combinationally on inst_word in its completion cycle.
module inst_queue #(
  parameter int NSHIFT     = 2,
  parameter int LOG2_DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  inst_queue_if.slave  bus
);
  localparam int DEPTH = 1 << LOG2_DEPTH;
  localparam int BEATS = 16 / NSHIFT;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = LOG2_DEPTH + 1;
  localparam int SW    = 8;

  logic [15:0]           fifo_q [DEPTH];
  logic [LOG2_DEPTH-1:0] rdPtr_q, rdPtr_d;
  logic [LOG2_DEPTH-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         reserved_q, reserved_d;
  logic [SW-1:0]         stale_q, stale_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [15:0]           asm_q, asm_d;
  logic [15:0]           imm_q, imm_d;
  logic                  loaded_q, loaded_d;

  logic [15:0] asmNext;
  logic        wordDone, staleDone, freshDone, pushReq;
  logic        qEmpty, qFull, bypassHit;
  logic        popFire, loadFire, headPop, bypassPop, doPush;
  logic [CW:0] occupancy;

  // Word assembly, request bookkeeping and the pop/push decisions
  always_comb begin
    asmNext   = {bus.rx_data, asm_q[15:NSHIFT]};
    wordDone  = bus.rx_valid && (beat_q == BW'(BEATS - 1));
    staleDone = wordDone && (stale_q != '0);
    freshDone = wordDone && (stale_q == '0);
    pushReq   = freshDone && !bus.flush;
    qEmpty    = (count_q == '0);
    qFull     = (count_q == CW'(DEPTH));
`ifdef INST_QUEUE_BYPASS_EN
    bypassHit = pushReq && qEmpty;
`else
    bypassHit = 1'b0;
`endif
    popFire   = bus.inst_word_pop && (!qEmpty || bypassHit) && !bus.load_imm16;
    loadFire  = bus.load_imm16 && !qEmpty && !loaded_q;
    headPop   = loadFire || (popFire && !qEmpty);
    bypassPop = popFire && qEmpty;
    doPush    = pushReq && !bypassPop && !qFull;
    occupancy = {1'b0, count_q} + {1'b0, reserved_q};
  end

  // Next-state for the queue occupancy, pointers, stale tracking and immediate
  always_comb begin
    count_d    = count_q;
    reserved_d = reserved_q;
    stale_d    = stale_q;
    rdPtr_d    = rdPtr_q;
    wrPtr_d    = wrPtr_q + LOG2_DEPTH'(doPush);
    beat_d     = beat_q;
    asm_d      = asm_q;
    imm_d      = imm_q;
    loaded_d   = loadFire;

    if (bus.flush) begin
      count_d    = '0;
      rdPtr_d    = wrPtr_q;
      stale_d    = stale_q + SW'(reserved_q) - SW'(staleDone);
      reserved_d = bus.req_issued ? CW'(1) : '0;
    end else begin
      count_d    = count_q + CW'(doPush) - CW'(headPop);
      rdPtr_d    = rdPtr_q + LOG2_DEPTH'(headPop);
      stale_d    = stale_q - SW'(staleDone);
      reserved_d = reserved_q + CW'(bus.req_issued)
                 - CW'(freshDone && (reserved_q != '0));
    end

    if (bus.rx_valid) begin
      asm_d  = asmNext;
      beat_d = wordDone ? '0 : beat_q + BW'(1);
    end

    if (loadFire) begin
      imm_d = fifo_q[rdPtr_q];
    end else if (bus.next_imm_data) begin
      imm_d = {imm_q[NSHIFT-1:0], imm_q[15:NSHIFT]};
    end
  end

  // State registers and FIFO storage
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr_q    <= '0;
      wrPtr_q    <= '0;
      count_q    <= '0;
      reserved_q <= '0;
      stale_q    <= '0;
      beat_q     <= '0;
      asm_q      <= '0;
      imm_q      <= '0;
      loaded_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      rdPtr_q    <= rdPtr_d;
      wrPtr_q    <= wrPtr_d;
      count_q    <= count_d;
      reserved_q <= reserved_d;
      stale_q    <= stale_d;
      beat_q     <= beat_d;
      asm_q      <= asm_d;
      imm_q      <= imm_d;
      loaded_q   <= loaded_d;
      if (doPush) begin
        fifo_q[wrPtr_q] <= asmNext;
      end
    end
  end

  assign bus.room            = (occupancy < (CW + 1)'(DEPTH));
  assign bus.inst_word_valid = (!qEmpty || bypassHit) && !bus.load_imm16;
`ifdef INST_QUEUE_BYPASS_EN
  assign bus.inst_word       = qEmpty ? asmNext : fifo_q[rdPtr_q];
`else
  assign bus.inst_word       = fifo_q[rdPtr_q];
`endif
  assign bus.imm16_loaded    = loaded_q;
  assign bus.imm_data        = imm_q[NSHIFT-1:0];

  // A word arriving into a full queue means the prefetcher ignored room
  overflowCheck: assert property (@(posedge clk) disable iff (reset)
    !(pushReq && !bypassPop && qFull));

endmodule
